mul_unit: RTL
=============

# mul_unit

Iterative shift-add multiplier for MUL/MLA, fed from the banked register file's read ports. Operands come from r_data_a (Rm), r_data_b (Rs) and r_data_c (Rn). The unit holds the pipeline via `busy`, then issues a one-cycle write-back request (`write_reg`, `w_addr`, `result`) to the register file, plus N/Z flags for the CPSR logic.

## Interface
- EARLY_TERM, 1: when 1, the iteration stops as soon as the remaining multiplier is zero; when 0, the unit always runs 32 iterations.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch request; sampled only in IDLE
- acc_en  in  1  1 = MLA (add op_n), 0 = MUL
- set_flags  in  1  request N/Z update
- rd_addr  in  4  destination register
- op_m  in  32  multiplicand (Rm)
- op_s  in  32  multiplier (Rs)
- op_n  in  32  accumulate operand (Rn)
- busy  out  1  high when state != IDLE
- done  out  1  one-cycle completion pulse
- result  out  32  product, low 32 bits
- w_addr  out  4  latched rd_addr
- write_reg  out  1  write-back strobe, one cycle
- flag_n, flag_z  out  1 each  result[31], (result == 0)
- flags_valid  out  1  done & latched set_flags
- error  out  1  one-cycle pulse; rd_addr was 15

## Operation
- **States:**
  - IDLE: on start=1, latch mcand=op_m, mplier=op_s, acc=(acc_en ? op_n : 0), rd, set_flags; go to CALC.
  - CALC: one iteration per cycle (see below).
  - DONE: lasts exactly 1 cycle, then back to IDLE.
- **Iteration (CALC):**
  - If mplier[0], acc = acc + mcand, modulo 2^32 (carry discarded).
  - mcand = mcand << 1; mplier = mplier >> 1; cnt = cnt + 1.
- **Exit CALC to DONE** after the iteration in which cnt reaches 32, or, when EARLY_TERM=1, after the iteration that leaves mplier == 0.
  - Iteration count k = 32 when EARLY_TERM=0.
  - Otherwise k = max(1, index of the highest set bit of op_s + 1).
- **On entry to DONE:** result = acc; done = 1; write_reg = (rd != 15); error = (rd == 15); w_addr = rd.
  - flag_n and flag_z are computed from the new result.
  - flags_valid = latched set_flags.
- **Ignored start:** start in CALC or DONE is ignored and not queued.
- **Operand sampling:** operands are sampled only on the accepted start edge. Later changes on the read ports do not affect the result.
- **Signedness:** signed and unsigned MUL give identical low 32 bits; no sign handling is needed.

## Timing
- **Reset values:** rst=1 at a rising edge forces IDLE, cnt=0, and all outputs to 0, including result and w_addr.
- **Reset mid-CALC or in DONE:** the operation is abandoned. No done, write_reg or error follows.
- **Latency:** start is sampled at edge E0. Iterations occur at edges E1..Ek. done, write_reg, result and flags are registered at edge Ek and high for the single cycle Ek..Ek+1.
  - The register file commits the write on the falling edge inside that cycle.
- **Back-to-back:** state is IDLE after Ek+1, so the earliest next start is sampled at Ek+1. Throughput is one operation per k+1 cycles.
- **Output hold:** result, w_addr, flag_n and flag_z hold until the next DONE or reset. done, write_reg, flags_valid and error are pulses.
- **No combinational paths:** no input reaches any output combinationally.

## Structure
- **Shared CPU package:**
  - state encoding (IDLE/CALC/DONE)
  - data-width constant 32
  - PC register index 4'd15
  - the N/Z flag bit positions
- **Single module:** the FSM, 6-bit counter and three 32-bit datapath registers stay in one module.
  - The iteration step is a few lines, so no sub-module is warranted.

## Test plan
- MUL after rst with op_m=3, op_s=5, rd=2, set_flags=1, EARLY_TERM=1 -> k=3.
  - done at E3 with result=15, w_addr=2, write_reg=1, N=0, Z=0, flags_valid=1.
- MLA with op_m=0xFFFFFFFF, op_s=2, op_n=1 -> k=2.
  - result=0xFFFFFFFF, N=1, Z=0.
- op_m=2, op_s=0x80000000 -> k=32.
  - result=0 (overflow discarded), Z=1; busy is high for 33 cycles.
- MLA with op_s=0, op_n=0x1234, EARLY_TERM=1 -> k=1.
  - result=0x1234 at E1.
  - Same stimulus with EARLY_TERM=0 -> done at E32.
- A second start pulsed during CALC is ignored: exactly one done occurs.
- rd_addr=15 -> error=1 and write_reg=0 on the done cycle.
- rst asserted at E5 of a k=32 operation -> busy=0 at E5.
  - No done/write_reg in the following 40 cycles; result=0.

Source files
------------

// File: rtl/mul_unit_pkg.sv
// Shared CPU package for the multiplier slice.
// Holds the multiplier FSM encoding, the datapath width, the PC register index
// and the positions of N/Z inside the two-bit flag vector handed to the CPSR logic.
package mul_unit_pkg;

   // Datapath and iteration sizing
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ITERATIONS = 32;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned REG_IDX_W  = 4;

   // Register index of the PC; a multiply may not write it back
   localparam logic [REG_IDX_W-1:0] PC_IDX = 4'd15;

   // Flag vector layout as consumed by the CPSR update logic
   localparam int unsigned NZ_W   = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_Z = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // N/Z for a 32-bit result, packed in the CPSR flag-vector order
   function automatic logic [NZ_W-1:0] nz_flags(input logic [DATA_W-1:0] value);
      logic [NZ_W-1:0] nz;
      nz         = '0;
      nz[FLAG_N] = value[DATA_W-1];
      nz[FLAG_Z] = (value == '0);
      return nz;
   endfunction

endpackage

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for MUL/MLA.
// Operands are captured from the register-file read ports when start is
// accepted in IDLE, one shift-add iteration runs per cycle in CALC, and a
// single DONE cycle presents the write-back request and N/Z flags.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        launch request, sampled only in IDLE
//   acc_en       1 = MLA (adds op_n), 0 = MUL
//   set_flags    request an N/Z update with this result
//   rd_addr      destination register
//   op_m/op_s/op_n  multiplicand (Rm), multiplier (Rs), accumuland (Rn)
//   busy         high whenever the FSM is not IDLE
//   done         one-cycle completion pulse
//   result       low 32 bits of the product (+ op_n), held until next DONE
//   w_addr       latched destination, held until next DONE
//   write_reg    one-cycle write-back strobe (suppressed for the PC)
//   flag_n/flag_z  N/Z of result, held until next DONE
//   flags_valid  done qualified by the latched set_flags
//   error        one-cycle pulse when the destination was the PC
module mul_unit
   import mul_unit_pkg::*;
#(
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        acc_en,
   input  logic        set_flags,
   input  logic [3:0]  rd_addr,
   input  logic [31:0] op_m,
   input  logic [31:0] op_s,
   input  logic [31:0] op_n,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [3:0]  w_addr,
   output logic        write_reg,
   output logic        flag_n,
   output logic        flag_z,
   output logic        flags_valid,
   output logic        error
);

   mul_state_t state, state_next;

   logic [DATA_W-1:0]    mcand, mcand_next;
   logic [DATA_W-1:0]    mplier, mplier_next;
   logic [DATA_W-1:0]    acc, acc_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [REG_IDX_W-1:0] rd, rd_next;
   logic                 sf, sf_next;

   logic                 busy_next;
   logic                 done_next;
   logic [DATA_W-1:0]    result_next;
   logic [REG_IDX_W-1:0] w_addr_next;
   logic                 write_reg_next;
   logic                 flag_n_next;
   logic                 flag_z_next;
   logic                 flags_valid_next;
   logic                 error_next;

   logic [DATA_W-1:0]    acc_step;
   logic [NZ_W-1:0]      nz;
   logic                 last_iter;

   // Next-state, datapath step and next-output values
   always_comb begin
      state_next       = state;
      mcand_next       = mcand;
      mplier_next      = mplier;
      acc_next         = acc;
      cnt_next         = cnt;
      rd_next          = rd;
      sf_next          = sf;
      done_next        = 1'b0;
      write_reg_next   = 1'b0;
      flags_valid_next = 1'b0;
      error_next       = 1'b0;
      result_next      = result;
      w_addr_next      = w_addr;
      flag_n_next      = flag_n;
      flag_z_next      = flag_z;
      acc_step         = acc;
      nz               = '0;
      last_iter        = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               mcand_next  = op_m;
               mplier_next = op_s;
               acc_next    = acc_en ? op_n : '0;
               cnt_next    = '0;
               rd_next     = rd_addr;
               sf_next     = set_flags;
               state_next  = CALC;
            end
         end

         CALC: begin
            // Add the shifted multiplicand when the current multiplier LSB is set
            acc_step    = mplier[0] ? (acc + mcand) : acc;
            acc_next    = acc_step;
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
            cnt_next    = cnt + CNT_W'(1);

            // Early exit once no multiplier bits remain (still at least one iteration)
            last_iter = (cnt_next == CNT_W'(ITERATIONS)) ||
                        (EARLY_TERM && (mplier_next == '0));

            if (last_iter) begin
               nz               = nz_flags(acc_step);
               state_next       = DONE;
               result_next      = acc_step;
               w_addr_next      = rd;
               done_next        = 1'b1;
               write_reg_next   = (rd != PC_IDX);
               error_next       = (rd == PC_IDX);
               flags_valid_next = sf;
               flag_n_next      = nz[FLAG_N];
               flag_z_next      = nz[FLAG_Z];
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         cnt         <= '0;
         rd          <= '0;
         sf          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result      <= '0;
         w_addr      <= '0;
         write_reg   <= 1'b0;
         flag_n      <= 1'b0;
         flag_z      <= 1'b0;
         flags_valid <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_next;
         mcand       <= mcand_next;
         mplier      <= mplier_next;
         acc         <= acc_next;
         cnt         <= cnt_next;
         rd          <= rd_next;
         sf          <= sf_next;
         busy        <= busy_next;
         done        <= done_next;
         result      <= result_next;
         w_addr      <= w_addr_next;
         write_reg   <= write_reg_next;
         flag_n      <= flag_n_next;
         flag_z      <= flag_z_next;
         flags_valid <= flags_valid_next;
         error       <= error_next;
      end
   end

endmodule
